// File: rtl/i2c_pkg.sv
// Shared definitions for the burst-mode I2C slave.
//   slave_state_t : 4-bit FSM encodings, also exported on slave_state
//   ACK / NACK    : SDA levels of the acknowledge bit
//   BIT_LAST      : bit down-counter reload (8 bits -> 7..0)
//   FETCH_CYCLES  : RD_FETCH down-counter reload (strobe, wait, load)
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_MADDR     = 4'd3,
    ST_MADDR_ACK = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RD_FETCH  = 4'd7,
    ST_RDATA     = 4'd8,
    ST_RDATA_ACK = 4'd9
  } slave_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [2:0] BIT_LAST     = 3'd7;
  localparam logic [2:0] FETCH_CYCLES = 3'd2;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser and bus-condition detector.
//   clk, reset   : system clock, synchronous active-high reset
//   scl, sda_in  : raw bus lines
//   sda_s        : synchronised SDA
//   scl_rise/fall: one-clk pulses on synchronised SCL edges
//   start_det    : one-clk pulse, SDA falls while SCL high
//   stop_det     : one-clk pulse, SDA rises while SCL high
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync[0] <= scl;
      sda_sync[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  // SCL must be high on both samples so an SCL edge never looks like START/STOP.
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_slave_burst.sv
// I2C slave bridging to a simple synchronous memory with burst access.
//   clk, reset          : system clock, synchronous active-high reset
//   id                  : own 7-bit device address
//   scl, sda_in, sda_oe : bus lines (sda_oe=1 pulls SDA low)
//   ce, rden, wren      : one-clk memory strobes
//   addr, wdata, rdata  : memory address / write data / read data (1 clk after rden)
//   busy                : START seen, STOP not yet seen
//   slave_state         : FSM encoding, slave_data : shift register
//
// state        | meaning
// IDLE         | waiting for START (also after NACK / address mismatch)
// DEV_ADDR     | shifting 7-bit device address + R/W
// DEV_ACK      | driving ACK for matched device address
// MADDR        | shifting a memory-address byte
// MADDR_ACK    | driving ACK for memory-address byte
// WDATA        | shifting a write-data byte
// WDATA_ACK    | driving ACK, then address increment
// RD_FETCH     | memory read strobe and load of shift register
// RDATA        | driving data bits, MSB first
// RDATA_ACK    | SDA released, sampling master ACK/NACK
module i2c_slave_burst
  import i2c_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter int ADDR_BYTES  = 1,
  parameter int MEM_DEPTH   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        id,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              ce,
  output logic              rden,
  output logic              wren,
  output logic [MEM_AW-1:0] addr,
  output logic [7:0]        wdata,
  input  logic [7:0]        rdata,
  output logic              busy,
  output logic [3:0]        slave_state,
  output logic [7:0]        slave_data
);

  localparam logic [MEM_AW-1:0] LAST_ADDR  = MEM_AW'(MEM_DEPTH - 1);
  localparam logic [16:0]       DEPTH_VAL  = 17'(MEM_DEPTH);
  localparam logic              BYTE_LAST  = 1'(ADDR_BYTES - 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  slave_state_t      state_q, state_n;
  logic [2:0]        bit_cnt_q, bit_cnt_n;
  logic [7:0]        shift_q, shift_n;
  logic [7:0]        acc_q, acc_n;
  logic              rw_q, rw_n;
  logic              byte_cnt_q, byte_cnt_n;
  logic              oe_q, oe_n;
  logic              ce_q, ce_n;
  logic              rden_q, rden_n;
  logic              wren_q, wren_n;
  logic [MEM_AW-1:0] addr_q, addr_n;
  logic [7:0]        wdata_q, wdata_n;
  logic              busy_q, busy_n;

  logic [7:0]        rx_byte;
  logic [15:0]       maddr_full;
  logic [MEM_AW-1:0] addr_inc;

  assign rx_byte    = {shift_q[6:0], sda_s};
  assign maddr_full = (ADDR_BYTES == 2) ? {acc_q, rx_byte} : {8'h00, rx_byte};
  assign addr_inc   = (addr_q == LAST_ADDR) ? '0 : addr_q + MEM_AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      rw_q       <= 1'b0;
      byte_cnt_q <= 1'b0;
      oe_q       <= 1'b0;
      ce_q       <= 1'b0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      acc_q      <= acc_n;
      rw_q       <= rw_n;
      byte_cnt_q <= byte_cnt_n;
      oe_q       <= oe_n;
      ce_q       <= ce_n;
      rden_q     <= rden_n;
      wren_q     <= wren_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      busy_q     <= busy_n;
    end
  end

  // ACK states use oe_q as their phase flag: the first SCL fall starts
  // driving the ACK, the second one (end of the 9th bit) releases it.
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shift_n    = shift_q;
    acc_n      = acc_q;
    rw_n       = rw_q;
    byte_cnt_n = byte_cnt_q;
    oe_n       = oe_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    busy_n     = busy_q;
    ce_n       = 1'b0;
    rden_n     = 1'b0;
    wren_n     = 1'b0;

    if (start_det) begin
      state_n   = ST_DEV_ADDR;
      bit_cnt_n = BIT_LAST;
      shift_n   = '0;
      acc_n     = '0;
      oe_n      = 1'b0;
      busy_n    = 1'b1;
    end else if (stop_det) begin
      state_n = ST_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_DEV_ADDR: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            rw_n    = sda_s;
            state_n = (shift_q[6:0] == id) ? ST_DEV_ACK : ST_IDLE;
          end
        end

        ST_DEV_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_n = 1'b1;
          end else begin
            oe_n       = 1'b0;
            bit_cnt_n  = BIT_LAST;
            byte_cnt_n = BYTE_LAST;
            state_n    = ST_MADDR;
          end
        end

        ST_MADDR: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            acc_n = rx_byte;
            if (byte_cnt_q != 1'b0) begin
              state_n = ST_MADDR_ACK;
            end else if ({1'b0, maddr_full} >= DEPTH_VAL) begin
              state_n = ST_IDLE;
            end else begin
              addr_n  = maddr_full[MEM_AW-1:0];
              state_n = ST_MADDR_ACK;
            end
          end
        end

        ST_MADDR_ACK: begin
          // Reads fetch during the ACK high phase so the MSB is ready
          // for the same SCL fall that releases the ACK.
          if (scl_rise && oe_q && byte_cnt_q == 1'b0 && rw_q) begin
            state_n   = ST_RD_FETCH;
            bit_cnt_n = FETCH_CYCLES;
          end else if (scl_fall) begin
            if (!oe_q) begin
              oe_n = 1'b1;
            end else begin
              oe_n      = 1'b0;
              bit_cnt_n = BIT_LAST;
              if (byte_cnt_q != 1'b0) begin
                byte_cnt_n = byte_cnt_q - 1'b1;
                state_n    = ST_MADDR;
              end else begin
                state_n = ST_WDATA;
              end
            end
          end
        end

        ST_WDATA: if (scl_rise) begin
          shift_n   = rx_byte;
          bit_cnt_n = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            wdata_n = rx_byte;
            ce_n    = 1'b1;
            wren_n  = 1'b1;
            state_n = ST_WDATA_ACK;
          end
        end

        ST_WDATA_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_n = 1'b1;
          end else begin
            oe_n      = 1'b0;
            addr_n    = addr_inc;
            bit_cnt_n = BIT_LAST;
            state_n   = ST_WDATA;
          end
        end

        ST_RD_FETCH: begin
          bit_cnt_n = bit_cnt_q - 3'd1;
          if (bit_cnt_q == FETCH_CYCLES) begin
            ce_n   = 1'b1;
            rden_n = 1'b1;
          end else if (bit_cnt_q == 3'd0) begin
            shift_n   = rdata;
            bit_cnt_n = BIT_LAST;
            state_n   = ST_RDATA;
          end
        end

        ST_RDATA: begin
          if (scl_fall) begin
            oe_n = ~shift_q[7];
          end else if (scl_rise) begin
            shift_n   = {shift_q[6:0], 1'b0};
            bit_cnt_n = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) state_n = ST_RDATA_ACK;
          end
        end

        ST_RDATA_ACK: begin
          if (scl_fall) begin
            oe_n = 1'b0;
          end else if (scl_rise) begin
            if (sda_s == ACK) begin
              addr_n    = addr_inc;
              bit_cnt_n = FETCH_CYCLES;
              state_n   = ST_RD_FETCH;
            end else begin
              state_n = ST_IDLE;
            end
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign sda_oe      = oe_q;
  assign ce          = ce_q;
  assign rden        = rden_q;
  assign wren        = wren_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign busy        = busy_q;
  assign slave_state = state_q;
  assign slave_data  = shift_q;

endmodule

// File: tb/tb_i2c_slave_burst.sv
// Bench for i2c_slave_burst: a bit-banged I2C master shared by two slaves
// (id 1 with 256 locations, id 3 with 16 locations), memory models, and
// queues of expected memory accesses and read bytes.
`timescale 1ns/1ps
module tb_i2c_slave_burst;
  import i2c_pkg::*;

  localparam int Q = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic scl_m, sda_m;
  logic sda_line;

  logic       oe_a, ce_a, rden_a, wren_a, busy_a;
  logic [7:0] addr_a, wdata_a, rdata_a, data_a;
  logic [3:0] st_a;

  logic       oe_b, ce_b, rden_b, wren_b, busy_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b, rdata_b, data_b;
  logic [3:0] st_b;

  assign sda_line = sda_m & ~oe_a & ~oe_b;

  i2c_slave_burst dut (
    .clk(clk), .reset(reset), .id(7'h01), .scl(scl_m), .sda_in(sda_line),
    .sda_oe(oe_a), .ce(ce_a), .rden(rden_a), .wren(wren_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .busy(busy_a), .slave_state(st_a),
    .slave_data(data_a)
  );

  i2c_slave_burst #(.MEM_AW(4), .MEM_DEPTH(16)) dut16 (
    .clk(clk), .reset(reset), .id(7'h03), .scl(scl_m), .sda_in(sda_line),
    .sda_oe(oe_b), .ce(ce_b), .rden(rden_b), .wren(wren_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .busy(busy_b), .slave_state(st_b),
    .slave_data(data_b)
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_data[$];

  int checks = 0;
  int errors = 0;
  int strobes_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (ce_a && rden_a) rdata_a <= mem_a[addr_a];
    if (ce_a && wren_a) mem_a[addr_a] <= wdata_a;
    if (ce_b && rden_b) rdata_b <= mem_b[addr_b];
    if (ce_b && wren_b) mem_b[addr_b] <= wdata_b;
  end

  always @(negedge clk) begin
    wr_t w;
    if (ce_a || rden_a || wren_a) begin
      check("strobe_pair", {31'b0, ce_a}, {31'b0, rden_a ^ wren_a});
      if (wren_a) begin
        checks++;
        assert (exp_wr.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr=%0h data=%0h expected no write", addr_a, wdata_a);
        end
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          check("write_addr", {24'b0, addr_a}, {24'b0, w.a});
          check("write_data", {24'b0, wdata_a}, {24'b0, w.d});
        end
      end
      if (rden_a) begin
        checks++;
        assert (exp_rd.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_read: observed addr=%0h expected no read", addr_a);
        end
        if (exp_rd.size() != 0) check("read_addr", {24'b0, addr_a}, {24'b0, exp_rd.pop_front()});
      end
    end
    if (ce_b || rden_b || wren_b) strobes_b++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic mack);
    for (int i = 7; i >= 0; i--) read_bit(v[i]);
    write_bit(mack);
  endtask

  task automatic send(input string tag, input logic [7:0] v, input logic exp_ack);
    logic ack;
    write_byte(v, ack);
    check(tag, {31'b0, ack}, {31'b0, exp_ack});
  endtask

  task automatic read_and_check(input string tag, input logic [7:0] e, input logic mack);
    logic [7:0] v;
    exp_data.push_back(e);
    read_byte(v, mack);
    check(tag, {24'b0, v}, {24'b0, exp_data.pop_front()});
  endtask

  initial begin
    logic b;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 16; i++)  mem_b[i] = 8'(i) ^ 8'hC3;
    mem_a[1] = 8'h05;
    rdata_a = '0;
    rdata_b = '0;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    check("rst_state",  {28'b0, st_a},   {28'b0, ST_IDLE});
    check("rst_oe",     {31'b0, oe_a},   32'd0);
    check("rst_ce",     {29'b0, ce_a, rden_a, wren_a}, 32'd0);
    check("rst_busy",   {31'b0, busy_a}, 32'd0);
    check("rst_addr",   {24'b0, addr_a}, 32'd0);
    check("rst_wdata",  {24'b0, wdata_a}, 32'd0);
    check("rst_data",   {24'b0, data_a}, 32'd0);
    reset = 1'b0;
    tick(5);

    // read one byte at address 1, master NACK
    bus_start();
    send("t1_dev_ack", {7'h01, 1'b1}, ACK);
    check("t1_busy", {31'b0, busy_a}, 32'd1);
    exp_rd.push_back(8'h01);
    send("t1_maddr_ack", 8'h01, ACK);
    read_and_check("t1_rdata", 8'h05, NACK);
    bus_stop();
    check("t1_state_idle", {28'b0, st_a}, {28'b0, ST_IDLE});
    check("t1_busy_low", {31'b0, busy_a}, 32'd0);

    // write 0x7F at address 2, then read it back
    bus_start();
    send("t2_dev_ack", {7'h01, 1'b0}, ACK);
    exp_wr.push_back('{a: 8'h02, d: 8'h7F});
    send("t2_maddr_ack", 8'h02, ACK);
    send("t2_data_ack", 8'h7F, ACK);
    bus_stop();
    bus_start();
    send("t2_rdev_ack", {7'h01, 1'b1}, ACK);
    exp_rd.push_back(8'h02);
    send("t2_rmaddr_ack", 8'h02, ACK);
    read_and_check("t2_readback", 8'h7F, NACK);
    bus_stop();

    // reset during bit 3 of a read of 0x05 (bit 3 is 0, so SDA is pulled)
    bus_start();
    send("t6_dev_ack", {7'h01, 1'b1}, ACK);
    exp_rd.push_back(8'h01);
    send("t6_maddr_ack", 8'h01, ACK);
    for (int i = 0; i < 3; i++) read_bit(b);
    check("t6_state_rdata", {28'b0, st_a}, {28'b0, ST_RDATA});
    check("t6_oe_driving", {31'b0, oe_a}, 32'd1);
    reset = 1'b1;
    tick(1);
    check("t6_oe_after_rst", {31'b0, oe_a}, 32'd0);
    check("t6_state_after_rst", {28'b0, st_a}, {28'b0, ST_IDLE});
    check("t6_data_after_rst", {24'b0, data_a}, 32'd0);
    reset = 1'b0;
    tick(2);
    bus_stop();
    bus_start();
    send("t6_rdev_ack", {7'h01, 1'b1}, ACK);
    exp_rd.push_back(8'h01);
    send("t6_rmaddr_ack", 8'h01, ACK);
    read_and_check("t6_readback", 8'h05, NACK);
    bus_stop();

    // wrong device address: no ACK, back to IDLE
    bus_start();
    send("t4_dev_nack", {7'h02, 1'b0}, NACK);
    check("t4_state_idle", {28'b0, st_a}, {28'b0, ST_IDLE});
    bus_stop();

    // 16-deep slave: out-of-range address NACKed, partial byte discarded
    bus_start();
    send("t5_dev_ack", {7'h03, 1'b0}, ACK);
    send("t5_maddr_nack", 8'h20, NACK);
    check("t5_state_idle", {28'b0, st_b}, {28'b0, ST_IDLE});
    bus_stop();
    bus_start();
    send("t5_dev2_ack", {7'h03, 1'b0}, ACK);
    send("t5_maddr2_ack", 8'h05, ACK);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    check("t5_busy_low", {31'b0, busy_b}, 32'd0);
    check("t5_state_end", {28'b0, st_b}, {28'b0, ST_IDLE});

    // burst write across the top of the address space
    bus_start();
    send("t3_dev_ack", {7'h01, 1'b0}, ACK);
    exp_wr.push_back('{a: 8'hFF, d: 8'hA1});
    exp_wr.push_back('{a: 8'h00, d: 8'hA2});
    exp_wr.push_back('{a: 8'h01, d: 8'hA3});
    send("t3_maddr_ack", 8'hFF, ACK);
    send("t3_d0_ack", 8'hA1, ACK);
    send("t3_d1_ack", 8'hA2, ACK);
    send("t3_d2_ack", 8'hA3, ACK);
    bus_stop();
    tick(5);

    check("pending_writes", exp_wr.size(), 32'd0);
    check("pending_reads", exp_rd.size(), 32'd0);
    check("dut16_strobes", strobes_b, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
